// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access stage: byte/half/word loads and stores over a req/ack port
// Optional misaligned-access trap: define MEM_MISALIGN_TRAP_EN.
module mem_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_enable_i,
    input  logic [4:0]        w_addr_i,
    input  logic [DATA_W-1:0] w_data_i,
    input  logic [3:0]        mem_op_i,
    input  logic [DATA_W-1:0] store_data_i,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_req_o,
    output logic              w_enable_o,
    output logic [4:0]        w_addr_o,
    output logic [DATA_W-1:0] w_data_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);

    localparam logic [3:0] OP_LB  = 4'b0001;
    localparam logic [3:0] OP_LH  = 4'b0010;
    localparam logic [3:0] OP_LW  = 4'b0011;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      r_state;
    logic [1:0]  r_lo;
    logic [3:0]  r_op;
    logic        r_wen;
    logic [4:0]  r_waddr;

    logic              w_is_load;
    logic              w_is_store;
    logic              w_trap;
    logic [3:0]        w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [DATA_W-1:0] w_load;
    logic              w_busy_is_load;

    always_comb begin
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_be       = 4'b1111;
        w_wdata    = store_data_i;
        case (mem_op_i)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: w_is_load = 1'b1;
            OP_SB: begin
                w_is_store = 1'b1;
                w_be       = 4'b0001 << w_data_i[1:0];
                w_wdata    = {4{store_data_i[7:0]}};
            end
            OP_SH: begin
                w_is_store = 1'b1;
                w_be       = w_data_i[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{store_data_i[15:0]}};
            end
            OP_SW: w_is_store = 1'b1;
            default: ;
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        w_trap = 1'b0;
        case (mem_op_i)
            OP_LH, OP_LHU, OP_SH: w_trap = w_data_i[0];
            OP_LW, OP_SW:         w_trap = (w_data_i[1:0] != 2'b00);
            default:              w_trap = 1'b0;
        endcase
    end
`else
    assign w_trap = 1'b0;
`endif

    // Lane extraction uses the address bits captured when the request was issued.
    always_comb begin
        w_byte = mem_rdata_i[{r_lo, 3'b000} +: 8];
        w_half = r_lo[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
        case (r_op)
            OP_LB:   w_load = {{(DATA_W-8){w_byte[7]}}, w_byte};
            OP_LBU:  w_load = {{(DATA_W-8){1'b0}}, w_byte};
            OP_LH:   w_load = {{(DATA_W-16){w_half[15]}}, w_half};
            OP_LHU:  w_load = {{(DATA_W-16){1'b0}}, w_half};
            default: w_load = mem_rdata_i;
        endcase
    end

    assign w_busy_is_load = (r_op == OP_LB) || (r_op == OP_LH) || (r_op == OP_LW) ||
                            (r_op == OP_LBU) || (r_op == OP_LHU);

    always_comb begin
        case (r_state)
            S_IDLE:  stall_req_o = (w_is_load | w_is_store) & ~w_trap;
            S_BUSY:  stall_req_o = ~mem_ack_i;
            default: stall_req_o = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_lo        <= 2'b00;
            r_op        <= 4'b0000;
            r_wen       <= 1'b0;
            r_waddr     <= 5'd0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_be_o    <= 4'b0000;
            mem_wdata_o <= '0;
            w_enable_o  <= 1'b0;
            w_addr_o    <= 5'd0;
            w_data_o    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o  <= 1'b0;
`endif
        end else begin
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_o <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (w_trap) begin
                        w_enable_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_o <= 1'b1;
`endif
                    end else if (w_is_load || w_is_store) begin
                        r_state     <= S_BUSY;
                        r_lo        <= w_data_i[1:0];
                        r_op        <= mem_op_i;
                        r_wen       <= w_enable_i;
                        r_waddr     <= w_addr_i;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= w_is_store;
                        mem_addr_o  <= {w_data_i[ADDR_W-1:2], 2'b00};
                        mem_be_o    <= w_be;
                        mem_wdata_o <= w_wdata;
                        w_enable_o  <= 1'b0;
                    end else begin
                        w_enable_o <= w_enable_i;
                        w_addr_o   <= w_addr_i;
                        w_data_o   <= w_data_i;
                    end
                end
                S_BUSY: begin
                    if (mem_ack_i) begin
                        r_state   <= S_IDLE;
                        mem_req_o <= 1'b0;
                        if (w_busy_is_load) begin
                            w_enable_o <= r_wen;
                            w_addr_o   <= r_waddr;
                            w_data_o   <= w_load;
                        end else begin
                            w_enable_o <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
